// File: rtl/pcss_inf_pkg.sv
// Shared definitions for the pcss_inf send-side logic.
//   DEF_DATA_WIDTH : default AXI-stream tdata width
//   state_e        : arbiter FSM encoding (IDLE / CFG / SPK)
//   GNT_*          : one-hot grant constants (bit0 = cfg, bit1 = spk)
//   state_to_grant : one-hot decode of an arbiter state
package pcss_inf_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CFG  = 2'd1,
        ST_SPK  = 2'd2
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CFG  = 2'b01;
    localparam logic [1:0] GNT_SPK  = 2'b10;

    // One-hot owner for a given arbiter state.
    function automatic logic [1:0] state_to_grant(state_e st);
        logic [1:0] gnt;
        gnt = GNT_NONE;
        case (st)
            ST_CFG:  gnt = GNT_CFG;
            ST_SPK:  gnt = GNT_SPK;
            default: gnt = GNT_NONE;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/pcss_tik_edge_cnt.sv
// Counts falling edges of the tik timestep pulse.
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset
//   tik_i     : tik pulse, synchronous to clk_i
//   tik_cnt_o : falling-edge count, wraps modulo 2**TIK_CNT
module pcss_tik_edge_cnt #(
    parameter int unsigned TIK_CNT = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tik_i,
    output logic [TIK_CNT-1:0] tik_cnt_o
);

    logic               tik_dly_q;
    logic [TIK_CNT-1:0] cnt_q;
    logic [TIK_CNT-1:0] cnt_d;

    // Increment on a 1 -> 0 transition; natural overflow gives the wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (tik_dly_q && !tik_i) begin
            cnt_d = cnt_q + TIK_CNT'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tik_dly_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            tik_dly_q <= tik_i;
            cnt_q     <= cnt_d;
        end
    end

    assign tik_cnt_o = cnt_q;

endmodule

// File: rtl/pcss_send_arb.sv
// Packet-level arbiter sharing the pcss_inf send port between the config
// stream (cfg, priority) and the spike stream (spk). Whole packets are
// granted and locked until tlast; spk is held off while tik is high and is
// forced in after STARVE_LIM consecutive cfg grants that it lost.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   s_cfg_* / s_spk_*    : AXI-stream slave inputs from the two requesters
//   m_*                  : AXI-stream master output to S_AXIS_send_*
//   tik                  : timestep pulse; tik_cnt counts its falling edges
//   grant, busy          : one-hot current owner and packet-locked flag
module pcss_send_arb
    import pcss_inf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned TIK_CNT    = 8,
    parameter int unsigned STARVE_LIM = 4,
    // 2**STARVE_W must exceed STARVE_LIM so the saturated value fits.
    parameter int unsigned STARVE_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_cfg_tdata,
    input  logic                    s_cfg_tvalid,
    input  logic                    s_cfg_tlast,
    input  logic [DATA_WIDTH/8-1:0] s_cfg_tkeep,
    output logic                    s_cfg_tready,
    input  logic [DATA_WIDTH-1:0]   s_spk_tdata,
    input  logic                    s_spk_tvalid,
    input  logic                    s_spk_tlast,
    input  logic [DATA_WIDTH/8-1:0] s_spk_tkeep,
    output logic                    s_spk_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    input  logic                    m_tready,
    input  logic                    tik,
    output logic [TIK_CNT-1:0]      tik_cnt,
    output logic [1:0]              grant,
    output logic                    busy
);

    state_e              state_q;
    state_e              state_d;
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;

    logic spk_elig;
    logic starve_ok;
    logic cfg_last_xfer;
    logic spk_last_xfer;

    assign spk_elig      = s_spk_tvalid & ~tik;
    assign starve_ok     = (starve_q < STARVE_W'(STARVE_LIM));
    assign cfg_last_xfer = s_cfg_tvalid & s_cfg_tlast & m_tready;
    assign spk_last_xfer = s_spk_tvalid & s_spk_tlast & m_tready;

    // State and starvation counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Arbitration in IDLE; locked states release only on the tlast beat.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            ST_IDLE: begin
                if (s_cfg_tvalid && (!spk_elig || starve_ok)) begin
                    state_d = ST_CFG;
                    // starve_ok holds here whenever spk_elig does, so this saturates.
                    if (spk_elig) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (spk_elig) begin
                    state_d  = ST_SPK;
                    starve_d = '0;
                end
            end
            ST_CFG: begin
                if (cfg_last_xfer) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SPK: begin
                if (spk_last_xfer) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Combinational passthrough of the owning source; everything quiet in IDLE.
    always_comb begin
        m_tdata      = '0;
        m_tkeep      = '0;
        m_tlast      = 1'b0;
        m_tvalid     = 1'b0;
        s_cfg_tready = 1'b0;
        s_spk_tready = 1'b0;
        grant        = state_to_grant(state_q);
        busy         = (state_q != ST_IDLE);
        unique case (state_q)
            ST_CFG: begin
                m_tdata      = s_cfg_tdata;
                m_tkeep      = s_cfg_tkeep;
                m_tlast      = s_cfg_tlast;
                m_tvalid     = s_cfg_tvalid;
                s_cfg_tready = m_tready;
            end
            ST_SPK: begin
                m_tdata      = s_spk_tdata;
                m_tkeep      = s_spk_tkeep;
                m_tlast      = s_spk_tlast;
                m_tvalid     = s_spk_tvalid;
                s_spk_tready = m_tready;
            end
            default: begin
            end
        endcase
    end

    pcss_tik_edge_cnt #(
        .TIK_CNT (TIK_CNT)
    ) u_tik_cnt (
        .clk_i     (clk),
        .rst_i     (rst),
        .tik_i     (tik),
        .tik_cnt_o (tik_cnt)
    );

endmodule

// File: tb/tb_pcss_send_arb.sv
// Self-checking bench for pcss_send_arb: directed scenarios plus a random
// traffic run scored against a packet-level reference model.
module tb_pcss_send_arb;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_CFG  = 2'b01;
    localparam logic [1:0] G_SPK  = 2'b10;
    localparam int         LIM    = 4;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_cfg_tdata;
    logic        s_cfg_tvalid;
    logic        s_cfg_tlast;
    logic [7:0]  s_cfg_tkeep;
    logic        s_cfg_tready;
    logic [63:0] s_spk_tdata;
    logic        s_spk_tvalid;
    logic        s_spk_tlast;
    logic [7:0]  s_spk_tkeep;
    logic        s_spk_tready;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [7:0]  m_tkeep;
    logic        m_tready;
    logic        tik;
    logic [7:0]  tik_cnt;
    logic [1:0]  grant;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pcss_send_arb #(
        .DATA_WIDTH (64),
        .TIK_CNT    (8),
        .STARVE_LIM (4),
        .STARVE_W   (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_cfg_tdata  (s_cfg_tdata),
        .s_cfg_tvalid (s_cfg_tvalid),
        .s_cfg_tlast  (s_cfg_tlast),
        .s_cfg_tkeep  (s_cfg_tkeep),
        .s_cfg_tready (s_cfg_tready),
        .s_spk_tdata  (s_spk_tdata),
        .s_spk_tvalid (s_spk_tvalid),
        .s_spk_tlast  (s_spk_tlast),
        .s_spk_tkeep  (s_spk_tkeep),
        .s_spk_tready (s_spk_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tlast      (m_tlast),
        .m_tkeep      (m_tkeep),
        .m_tready     (m_tready),
        .tik          (tik),
        .tik_cnt      (tik_cnt),
        .grant        (grant),
        .busy         (busy)
    );

    // Advance one clock; inputs are driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_cfg_tdata  = '0; s_cfg_tvalid = 1'b0; s_cfg_tlast = 1'b0; s_cfg_tkeep = '0;
        s_spk_tdata  = '0; s_spk_tvalid = 1'b0; s_spk_tlast = 1'b0; s_spk_tkeep = '0;
        m_tready     = 1'b0;
        tik          = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_cfg_tvalid = 1'b1; s_cfg_tdata = {$urandom, $urandom}; s_cfg_tlast = 1'b1; s_cfg_tkeep = 8'hFF;
        s_spk_tvalid = 1'b1; s_spk_tdata = {$urandom, $urandom}; s_spk_tlast = 1'b1; s_spk_tkeep = 8'hFF;
        m_tready = 1'b1; tik = 1'b0;
        step();
        #2;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_m_tvalid got=%0h want=0", m_tvalid); end
        total++; if (m_tlast !== 1'b0) begin bad++; $display("FAIL reset_m_tlast got=%0h want=0", m_tlast); end
        total++; if (m_tdata !== 64'h0) begin bad++; $display("FAIL reset_m_tdata got=%0h want=0", m_tdata); end
        total++; if (m_tkeep !== 8'h0) begin bad++; $display("FAIL reset_m_tkeep got=%0h want=0", m_tkeep); end
        total++; if (s_cfg_tready !== 1'b0) begin bad++; $display("FAIL reset_cfg_tready got=%0h want=0", s_cfg_tready); end
        total++; if (s_spk_tready !== 1'b0) begin bad++; $display("FAIL reset_spk_tready got=%0h want=0", s_spk_tready); end
        total++; if (grant !== G_NONE) begin bad++; $display("FAIL reset_grant got=%0h want=0", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h want=0", busy); end
        total++; if (tik_cnt !== 8'h0) begin bad++; $display("FAIL reset_tik_cnt got=%0h want=0", tik_cnt); end
        do_reset();
    endtask

    // 3-beat cfg packet: one-cycle arbitration latency, beats in order, lock released after tlast.
    task automatic test_cfg_packet();
        do_reset();
        m_tready = 1'b1;
        s_cfg_tvalid = 1'b1; s_cfg_tdata = 64'h1; s_cfg_tlast = 1'b0; s_cfg_tkeep = 8'hFF;
        #2;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL cfg_latency_idle got=%0h want=0", m_tvalid); end
        for (int b = 1; b <= 3; b++) begin
            step();
            s_cfg_tdata = 64'(b);
            s_cfg_tlast = (b == 3);
            #2;
            total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL cfg_beat%0d_valid got=%0h want=1", b, m_tvalid); end
            total++; if (m_tdata !== 64'(b)) begin bad++; $display("FAIL cfg_beat%0d_data got=%0h want=%0h", b, m_tdata, b); end
            total++; if (m_tlast !== (b == 3)) begin bad++; $display("FAIL cfg_beat%0d_last got=%0h want=%0h", b, m_tlast, (b == 3)); end
            total++; if (grant !== G_CFG) begin bad++; $display("FAIL cfg_beat%0d_grant got=%0h want=%0h", b, grant, G_CFG); end
        end
        step();
        s_cfg_tvalid = 1'b0;
        #2;
        total++; if (grant !== G_NONE) begin bad++; $display("FAIL cfg_unlock_grant got=%0h want=0", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cfg_unlock_busy got=%0h want=0", busy); end
    endtask

    // Both sources always valid with 1-beat packets: spk wins every fifth grant.
    task automatic test_starvation();
        logic [63:0] cdat = 64'hC000;
        logic [63:0] sdat = 64'h5000;
        int pk = 0;
        logic [1:0] won;
        logic [1:0] want;
        do_reset();
        m_tready = 1'b1;
        s_cfg_tvalid = 1'b1; s_cfg_tlast = 1'b1; s_cfg_tkeep = 8'hFF; s_cfg_tdata = cdat;
        s_spk_tvalid = 1'b1; s_spk_tlast = 1'b1; s_spk_tkeep = 8'hFF; s_spk_tdata = sdat;
        for (int cyc = 0; cyc < 60 && pk < 15; cyc++) begin
            #2;
            won = G_NONE;
            if (m_tvalid && m_tready) begin
                want = ((pk % (LIM + 1)) == LIM) ? G_SPK : G_CFG;
                total++; if (grant !== want) begin bad++; $display("FAIL starve_pkt%0d_grant got=%0h want=%0h", pk, grant, want); end
                total++; if (m_tdata !== ((want == G_CFG) ? cdat : sdat)) begin bad++; $display("FAIL starve_pkt%0d_data got=%0h want=%0h", pk, m_tdata, (want == G_CFG) ? cdat : sdat); end
                won = grant;
                pk++;
            end
            step();
            if (won == G_CFG) begin cdat = cdat + 64'h1; s_cfg_tdata = cdat; end
            if (won == G_SPK) begin sdat = sdat + 64'h1; s_spk_tdata = sdat; end
        end
        total++; if (pk != 15) begin bad++; $display("FAIL starve_pkt_count got=%0d want=15", pk); end
        idle_inputs();
    endtask

    // spk held off while tik is high; granted one cycle after tik falls.
    task automatic test_tik_block();
        do_reset();
        m_tready = 1'b1;
        s_spk_tvalid = 1'b1; s_spk_tdata = 64'hABC; s_spk_tlast = 1'b1; s_spk_tkeep = 8'h0F;
        tik = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            total++; if (grant !== G_NONE) begin bad++; $display("FAIL tik_block_c%0d_grant got=%0h want=0", c, grant); end
            total++; if (s_spk_tready !== 1'b0) begin bad++; $display("FAIL tik_block_c%0d_tready got=%0h want=0", c, s_spk_tready); end
            step();
        end
        tik = 1'b0;
        #2;
        total++; if (grant !== G_NONE) begin bad++; $display("FAIL tik_fall_grant got=%0h want=0", grant); end
        total++; if (tik_cnt !== 8'd0) begin bad++; $display("FAIL tik_fall_cnt_before got=%0h want=0", tik_cnt); end
        step();
        #2;
        total++; if (grant !== G_SPK) begin bad++; $display("FAIL tik_after_grant got=%0h want=%0h", grant, G_SPK); end
        total++; if (m_tdata !== 64'hABC) begin bad++; $display("FAIL tik_after_data got=%0h want=abc", m_tdata); end
        total++; if (m_tkeep !== 8'h0F) begin bad++; $display("FAIL tik_after_keep got=%0h want=f", m_tkeep); end
        total++; if (tik_cnt !== 8'd1) begin bad++; $display("FAIL tik_after_cnt got=%0h want=1", tik_cnt); end
        step();
        s_spk_tvalid = 1'b0;
    endtask

    // 4-beat spk packet under a 1,0,0 m_tready pattern with cfg waiting.
    task automatic test_backpressure();
        int xfers = 0;
        bit hs;
        do_reset();
        m_tready = 1'b1;
        s_spk_tvalid = 1'b1; s_spk_tdata = 64'hD1; s_spk_tlast = 1'b0; s_spk_tkeep = 8'hFF;
        step();
        s_cfg_tvalid = 1'b1; s_cfg_tdata = 64'hEE; s_cfg_tlast = 1'b1; s_cfg_tkeep = 8'hFF;
        for (int cyc = 0; cyc < 40 && xfers < 4; cyc++) begin
            m_tready = ((cyc % 3) == 0);
            #2;
            total++; if (s_cfg_tready !== 1'b0) begin bad++; $display("FAIL bp_c%0d_cfg_tready got=%0h want=0", cyc, s_cfg_tready); end
            total++; if (grant !== G_SPK) begin bad++; $display("FAIL bp_c%0d_grant got=%0h want=%0h", cyc, grant, G_SPK); end
            total++; if (m_tdata !== 64'hD1 + 64'(xfers)) begin bad++; $display("FAIL bp_c%0d_data got=%0h want=%0h", cyc, m_tdata, 64'hD1 + 64'(xfers)); end
            hs = m_tvalid && m_tready;
            step();
            if (hs) begin
                xfers++;
                if (xfers == 4) begin
                    s_spk_tvalid = 1'b0;
                end else begin
                    s_spk_tdata = 64'hD1 + 64'(xfers);
                    s_spk_tlast = (xfers == 3);
                end
            end
        end
        total++; if (xfers != 4) begin bad++; $display("FAIL bp_xfer_count got=%0d want=4", xfers); end
        #2;
        total++; if (grant !== G_NONE) begin bad++; $display("FAIL bp_unlock_grant got=%0h want=0", grant); end
        m_tready = 1'b1;
        step();
        #2;
        total++; if (grant !== G_CFG) begin bad++; $display("FAIL bp_cfg_next_grant got=%0h want=%0h", grant, G_CFG); end
        step();
        idle_inputs();
    endtask

    // Reset in the middle of a 6-beat cfg packet.
    task automatic test_reset_mid_packet();
        do_reset();
        for (int p = 0; p < 3; p++) begin
            tik = 1'b1; step();
            tik = 1'b0; step();
        end
        #2;
        total++; if (tik_cnt !== 8'd3) begin bad++; $display("FAIL rmid_tik_pre got=%0h want=3", tik_cnt); end
        m_tready = 1'b1;
        s_cfg_tvalid = 1'b1; s_cfg_tdata = 64'h61; s_cfg_tlast = 1'b0; s_cfg_tkeep = 8'hFF;
        step();
        for (int b = 1; b <= 2; b++) begin
            #2;
            total++; if (m_tdata !== 64'h60 + 64'(b)) begin bad++; $display("FAIL rmid_beat%0d got=%0h want=%0h", b, m_tdata, 64'h60 + 64'(b)); end
            step();
            s_cfg_tdata = 64'h60 + 64'(b + 1);
        end
        rst = 1'b1;
        #2;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rmid_m_tvalid got=%0h want=0", m_tvalid); end
        total++; if (s_cfg_tready !== 1'b0) begin bad++; $display("FAIL rmid_cfg_tready got=%0h want=0", s_cfg_tready); end
        total++; if (grant !== G_NONE) begin bad++; $display("FAIL rmid_grant got=%0h want=0", grant); end
        total++; if (tik_cnt !== 8'd0) begin bad++; $display("FAIL rmid_tik_cnt got=%0h want=0", tik_cnt); end
        step();
        rst = 1'b0;
        #2;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rmid_rearb_idle got=%0h want=0", m_tvalid); end
        step();
        #2;
        total++; if (grant !== G_CFG) begin bad++; $display("FAIL rmid_regrant got=%0h want=%0h", grant, G_CFG); end
        total++; if (m_tdata !== 64'h63) begin bad++; $display("FAIL rmid_regrant_data got=%0h want=63", m_tdata); end
        idle_inputs();
    endtask

    // 256 tik pulses: counter follows the pulse count modulo 256.
    task automatic test_tik_wrap();
        int exp_cnt = 0;
        do_reset();
        for (int p = 1; p <= 256; p++) begin
            tik = 1'b1; step();
            tik = 1'b0; step();
            #2;
            exp_cnt = (exp_cnt + 1) % 256;
            total++; if (tik_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL tik_wrap_p%0d got=%0h want=%0h", p, tik_cnt, exp_cnt); end
        end
    endtask

    // Random traffic, tik and backpressure against a packet-level model.
    task automatic test_random_traffic();
        beat_t       cfg_b[$];
        beat_t       spk_b[$];
        beat_t       bt;
        int          ci = 0, si = 0, co = 0, so = 0;
        int          streak = 0;
        int          exp_tik = 0;
        logic        prev_tik = 1'b0;
        logic [1:0]  pred = G_NONE;
        bit          have_pred = 1'b0;
        bit          c_acc, s_acc, elig;
        logic [1:0]  g;
        int          len;
        do_reset();
        for (int p = 0; p < 12; p++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                bt.data = {$urandom, $urandom}; bt.keep = 8'($urandom); bt.last = (b == len - 1);
                cfg_b.push_back(bt);
            end
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                bt.data = {$urandom, $urandom}; bt.keep = 8'($urandom); bt.last = (b == len - 1);
                spk_b.push_back(bt);
            end
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!s_cfg_tvalid && ci < cfg_b.size()) s_cfg_tvalid = ($urandom_range(0, 3) != 0);
            if (ci < cfg_b.size()) begin
                s_cfg_tdata = cfg_b[ci].data; s_cfg_tkeep = cfg_b[ci].keep; s_cfg_tlast = cfg_b[ci].last;
            end
            if (!s_spk_tvalid && si < spk_b.size()) s_spk_tvalid = ($urandom_range(0, 3) != 0);
            if (si < spk_b.size()) begin
                s_spk_tdata = spk_b[si].data; s_spk_tkeep = spk_b[si].keep; s_spk_tlast = spk_b[si].last;
            end
            tik      = ($urandom_range(0, 4) == 0);
            m_tready = ($urandom_range(0, 2) != 0);
            #2;
            g = grant;
            total++; if (tik_cnt !== 8'(exp_tik)) begin bad++; $display("FAIL rnd_c%0d_tik_cnt got=%0h want=%0h", cyc, tik_cnt, exp_tik); end
            if (have_pred) begin
                total++; if (g !== pred) begin bad++; $display("FAIL rnd_c%0d_grant got=%0h want=%0h", cyc, g, pred); end
            end
            have_pred = 1'b1;
            if (g == G_NONE) begin
                total++; if ({m_tvalid, s_cfg_tready, s_spk_tready} !== 3'b000) begin bad++; $display("FAIL rnd_c%0d_idle_quiet got=%0h want=0", cyc, {m_tvalid, s_cfg_tready, s_spk_tready}); end
                elig = s_spk_tvalid && !tik;
                if (s_cfg_tvalid && (!elig || streak < LIM)) begin
                    pred = G_CFG;
                    if (elig) streak++;
                end else if (elig) begin
                    pred = G_SPK;
                    streak = 0;
                end else begin
                    pred = G_NONE;
                end
            end else if (g == G_CFG || g == G_SPK) begin
                total++; if (s_cfg_tready !== ((g == G_CFG) ? m_tready : 1'b0)) begin bad++; $display("FAIL rnd_c%0d_cfg_tready got=%0h want=%0h", cyc, s_cfg_tready, (g == G_CFG) ? m_tready : 1'b0); end
                total++; if (s_spk_tready !== ((g == G_SPK) ? m_tready : 1'b0)) begin bad++; $display("FAIL rnd_c%0d_spk_tready got=%0h want=%0h", cyc, s_spk_tready, (g == G_SPK) ? m_tready : 1'b0); end
                total++; if (m_tvalid !== ((g == G_CFG) ? s_cfg_tvalid : s_spk_tvalid)) begin bad++; $display("FAIL rnd_c%0d_m_tvalid got=%0h want=%0h", cyc, m_tvalid, (g == G_CFG) ? s_cfg_tvalid : s_spk_tvalid); end
                pred = g;
                if (m_tvalid && m_tready) begin
                    if (g == G_CFG && co < cfg_b.size()) begin
                        bt = cfg_b[co]; co++;
                    end else if (g == G_SPK && so < spk_b.size()) begin
                        bt = spk_b[so]; so++;
                    end else begin
                        bt = '0;
                    end
                    total++; if ({m_tdata, m_tkeep, m_tlast} !== bt) begin bad++; $display("FAIL rnd_c%0d_beat got=%0h want=%0h", cyc, {m_tdata, m_tkeep, m_tlast}, bt); end
                    if (m_tlast) pred = G_NONE;
                end
            end else begin
                total++; bad++; $display("FAIL rnd_c%0d_grant_onehot got=%0h want=1or2", cyc, g);
            end
            if (prev_tik && !tik) exp_tik = (exp_tik + 1) % 256;
            prev_tik = tik;
            c_acc = s_cfg_tvalid && s_cfg_tready;
            s_acc = s_spk_tvalid && s_spk_tready;
            step();
            if (c_acc) begin ci++; s_cfg_tvalid = 1'b0; end
            if (s_acc) begin si++; s_spk_tvalid = 1'b0; end
            if (co == cfg_b.size() && so == spk_b.size()) break;
        end
        total++; if (co != cfg_b.size()) begin bad++; $display("FAIL rnd_cfg_drained got=%0d want=%0d", co, cfg_b.size()); end
        total++; if (so != spk_b.size()) begin bad++; $display("FAIL rnd_spk_drained got=%0d want=%0d", so, spk_b.size()); end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_cfg_packet();
        test_starvation();
        test_tik_block();
        test_backpressure();
        test_reset_mid_packet();
        test_tik_wrap();
        test_random_traffic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcss_send_arb.md
Name: pcss_send_arb

Overview:
- Packet-level arbiter placed in front of the pcss_inf AXI-stream send port (S_AXIS_send_*).
- Shares that port between two requesters: the configuration stream (source 0, cfg) and the spike-input stream (source 1, spk).
- Grants whole packets, locked until tlast. Gives cfg priority, with a starvation limit so spk still gets through.
- Blocks spike packets while tik is high, and counts tik falling edges for host-side timestep bookkeeping.

Parameters:
DATA_WIDTH, 64, AXI-stream tdata width; tkeep width is DATA_WIDTH/8
TIK_CNT, 8, width of the tik falling-edge counter
STARVE_LIM, 4, consecutive cfg grants allowed while spk is eligible before spk is forced in
STARVE_W, 3, width of starve counter; must satisfy 2**STARVE_W > STARVE_LIM

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
s_cfg_tdata  in  DATA_WIDTH  config stream data
s_cfg_tvalid  in  1  config valid
s_cfg_tlast  in  1  config end-of-packet
s_cfg_tkeep  in  DATA_WIDTH/8  config byte enables
s_cfg_tready  out  1  config ready
s_spk_tdata  in  DATA_WIDTH  spike stream data
s_spk_tvalid  in  1  spike valid
s_spk_tlast  in  1  spike end-of-packet
s_spk_tkeep  in  DATA_WIDTH/8  spike byte enables
s_spk_tready  out  1  spike ready
m_tdata  out  DATA_WIDTH  to pcss_inf S_AXIS_send_tdata
m_tvalid  out  1  to S_AXIS_send_tvalid
m_tlast  out  1  to S_AXIS_send_tlast
m_tkeep  out  DATA_WIDTH/8  to S_AXIS_send_tkeep
m_tready  in  1  from S_AXIS_send_tready
tik  in  1  timestep pulse from pcss_inf, synchronous to clk
tik_cnt  out  TIK_CNT  count of tik falling edges, wraps modulo 2**TIK_CNT
grant  out  2  one-hot current owner: bit0 = cfg, bit1 = spk; 00 = idle
busy  out  1  high while a packet is locked (grant != 0)

Behaviour:
- FSM states: IDLE, CFG, SPK. The state is registered; grant is the one-hot decode of the state.
- Reset (rst=1, asynchronous):
  - state=IDLE, starve_cnt=0, tik_dly=0, tik_cnt=0.
  - All outputs are 0: m_tvalid, m_tlast, m_tdata, m_tkeep, s_cfg_tready, s_spk_tready, grant, busy.
- Spike eligibility: spk_elig = s_spk_tvalid & ~tik.
- IDLE arbitration, evaluated every cycle:
  - s_cfg_tvalid & (~spk_elig | starve_cnt < STARVE_LIM) -> CFG. If spk_elig, starve_cnt increments (saturating).
  - Else if spk_elig -> SPK, and starve_cnt clears to 0.
  - Else stay in IDLE.
  - Arbitration latency: 1 cycle from tvalid in IDLE to the first m_tvalid.
- CFG or SPK (locked): the datapath is combinational passthrough of the selected source.
  - m_tdata/m_tkeep/m_tlast/m_tvalid = selected source's signals.
  - selected s_*_tready = m_tready; the unselected source's tready = 0.
- In IDLE: m_tvalid=0, both treadys=0, m_tdata/m_tkeep/m_tlast driven 0.
- Unlock: a beat with m_tvalid & m_tready & m_tlast returns the FSM to IDLE on the next edge. There is no back-to-back grant in the same cycle; one idle cycle between packets is required.
- Locked-packet rules:
  - A locked packet is never preempted.
  - tik rising during an SPK packet does not stop it.
  - tvalid dropping mid-packet holds the lock and emits no beats.
- AXI rules:
  - m_tdata/m_tkeep/m_tlast are stable whenever m_tvalid=1 and m_tready=0, provided the source obeys AXI.
  - A single-beat packet (tlast on the first beat) is legal.
- tik counter: tik_dly <= tik every cycle; tik_dly & ~tik increments tik_cnt, wrapping from 2**TIK_CNT-1 to 0.
- starve_cnt saturates at STARVE_LIM. It is unaffected by cfg grants when spk is not eligible.
- Reset mid-packet: the lock drops immediately and the outputs return to reset values. The upstream must restart the packet.

Decomposition:
- Shared package pcss_inf_pkg holds:
  - the DATA_WIDTH default
  - state encodings ST_IDLE=2'd0, ST_CFG=2'd1, ST_SPK=2'd2
  - grant one-hot constants GNT_CFG=2'b01, GNT_SPK=2'b10
- One natural sub-module, pcss_tik_edge_cnt: tik delay register plus wrapping falling-edge counter, parameterised by TIK_CNT. It is reusable by the receive-side logic.
- Arbitration and mux stay in the top module.

Test Plan:
1. Reset, then a 3-beat cfg packet (tdata 0x1,0x2,0x3, tlast on the 3rd) with m_tready=1 -> m_tvalid first high 1 cycle after s_cfg_tvalid; m beats 0x1,0x2,0x3; grant=01 throughout; IDLE on the cycle after the last beat.
2. cfg and spk both continuously valid with 1-beat packets, tik=0, STARVE_LIM=4 -> grant sequence cfg,cfg,cfg,cfg,spk, repeating; starve_cnt returns to 0 after each spk grant.
3. spk valid with tik=1 for 5 cycles, cfg idle -> no grant while tik=1; SPK granted 1 cycle after tik falls; tik_cnt increments by 1.
4. Backpressure: 4-beat spk packet with m_tready toggling 1,0,0,1,... -> exactly 4 transfers; m_tdata held stable during stalls; s_cfg_tready=0 throughout even with cfg valid.
5. Assert rst for 1 cycle mid-way through a 6-beat cfg packet (after beat 2) -> m_tvalid, s_cfg_tready and grant are 0 immediately; tik_cnt=0; the next cfg beat is granted as a new packet.
6. 256 tik pulses with TIK_CNT=8 -> tik_cnt reads 255 after pulse 255 and wraps to 0 after pulse 256.
